census_match: RTL and testbench

CENSUS_MATCH -- requirements
Module: census_match

---
 rtl/census_pkg.sv | 23 ++
 rtl/census_match_if.sv | 29 ++
 rtl/hamming_cost.sv | 12 +
 rtl/census_match.sv | 135 +++++++++++++
 tb/tb_census_match.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/census_pkg.sv
// Shared widths and constants for the census matching pipeline.
package census_pkg;

  localparam int CENSUS_W = 24;
  localparam int COST_W   = 5;
  localparam int COORD_W  = 13;
  localparam int DISP_W   = 8;

  // Cost assigned to candidates that fall off the left edge of the row.
  // Larger than any real Hamming cost (max 24), so it can never win.
  localparam logic [COST_W-1:0] COST_INV = 5'h1F;

  // Number of set bits in a census signature.
  function automatic logic [COST_W-1:0] popcount(input logic [CENSUS_W-1:0] v);
    logic [COST_W-1:0] n;
    n = '0;
    for (int i = 0; i < CENSUS_W; i++) begin
      n = n + COST_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/census_match_if.sv
// Pixel-stream bus into and out of the census matcher.
interface census_match_if;
  import census_pkg::*;

  logic                valid_in;
  logic [CENSUS_W-1:0] censusL;
  logic [CENSUS_W-1:0] censusR;
  logic [COORD_W-1:0]  row;
  logic [COORD_W-1:0]  col;

  logic                valid_out;
  logic [DISP_W-1:0]   disp;
  logic [COST_W-1:0]   cost;
  logic [COORD_W-1:0]  rowout;
  logic [COORD_W-1:0]  colout;

  // Upstream source / downstream sink side.
  modport master (
    output valid_in, censusL, censusR, row, col,
    input  valid_out, disp, cost, rowout, colout
  );

  // The matcher itself.
  modport slave (
    input  valid_in, censusL, censusR, row, col,
    output valid_out, disp, cost, rowout, colout
  );

endinterface

// File: rtl/hamming_cost.sv
// Hamming distance between two census signatures (purely combinational).
module hamming_cost
  import census_pkg::*;
(
  input  logic [CENSUS_W-1:0] a,
  input  logic [CENSUS_W-1:0] b,
  output logic [COST_W-1:0]   cost
);

  assign cost = popcount(a ^ b);

endmodule

// File: rtl/census_match.sv
// Census-transform stereo matcher: compares the left signature against the
// last D right signatures, then picks the cheapest disparity with a
// registered binary min-tree. Fixed latency LAT = log2(D)+1, no stalls.
module census_match
  import census_pkg::*;
#(
  parameter int D = 16
) (
  input  logic          clk,
  input  logic          rst,
  census_match_if.slave bus
);

  localparam int LOG2D = $clog2(D);
  localparam int LAT   = LOG2D + 1;

  // Right-image history; window[d] is the sample accepted d samples ago,
  // window[0] being the one presented this cycle.
  logic [CENSUS_W-1:0] hist_reg [D-1];
  logic [CENSUS_W-1:0] window   [D];

  // Per-candidate costs before and after the row-edge mask.
  logic [COST_W-1:0] raw_cost  [D];
  logic [COST_W-1:0] cand_cost [D];

  // Stage 1 holds the leaf costs; internal tree nodes live in heap order
  // (node 1 = root, children of k are 2k and 2k+1, leaf d sits at D+d).
  logic [COST_W-1:0] s1_cost_reg   [D];
  logic [COST_W-1:0] tree_cost_reg [1:D-1];
  logic [DISP_W-1:0] tree_idx_reg  [1:D-1];

  // Uniform view of every non-root node, feeding its parent.
  logic [COST_W-1:0] node_cost [2:2*D-1];
  logic [DISP_W-1:0] node_idx  [2:2*D-1];

  // Sideband pipeline; index t is the output of pipeline stage t+1.
  logic [LAT-1:0]     valid_reg;
  logic [COORD_W-1:0] row_reg [LAT];
  logic [COORD_W-1:0] col_reg [LAT];

  assign window[0] = bus.censusR;

  genvar gi;
  generate
    for (gi = 1; gi < D; gi++) begin : g_window
      assign window[gi] = hist_reg[gi-1];
    end

    // One Hamming unit per candidate; candidates left of column 0 are masked.
    for (gi = 0; gi < D; gi++) begin : g_cost
      hamming_cost u_ham (
        .a    (bus.censusL),
        .b    (window[gi]),
        .cost (raw_cost[gi])
      );
      assign cand_cost[gi] = (COORD_W'(gi) > bus.col) ? COST_INV : raw_cost[gi];
    end

    for (gi = 0; gi < D; gi++) begin : g_leaf
      assign node_cost[D+gi] = s1_cost_reg[gi];
      assign node_idx[D+gi]  = DISP_W'(gi);
    end

    for (gi = 2; gi < D; gi++) begin : g_inner
      assign node_cost[gi] = tree_cost_reg[gi];
      assign node_idx[gi]  = tree_idx_reg[gi];
    end
  endgenerate

  // Shift the right-image history only when a sample is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D-1; i++) begin
        hist_reg[i] <= '0;
      end
    end else if (bus.valid_in) begin
      hist_reg[0] <= bus.censusR;
      for (int i = 1; i < D-1; i++) begin
        hist_reg[i] <= hist_reg[i-1];
      end
    end
  end

  // Capture leaf costs, then reduce pairwise per stage; the left child has
  // the smaller disparity and keeps ties. Data moves only with a valid tag,
  // so the root (the outputs) holds its value across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      for (int i = 0; i < LAT; i++) begin
        row_reg[i] <= '0;
        col_reg[i] <= '0;
      end
      for (int i = 0; i < D; i++) begin
        s1_cost_reg[i] <= '0;
      end
      for (int k = 1; k < D; k++) begin
        tree_cost_reg[k] <= '0;
        tree_idx_reg[k]  <= '0;
      end
    end else begin
      valid_reg[0] <= bus.valid_in;
      if (bus.valid_in) begin
        row_reg[0] <= bus.row;
        col_reg[0] <= bus.col;
        for (int i = 0; i < D; i++) begin
          s1_cost_reg[i] <= cand_cost[i];
        end
      end
      for (int t = 1; t < LAT; t++) begin
        valid_reg[t] <= valid_reg[t-1];
        if (valid_reg[t-1]) begin
          row_reg[t] <= row_reg[t-1];
          col_reg[t] <= col_reg[t-1];
          for (int k = (D >> t); k < (D >> (t-1)); k++) begin
            if (node_cost[2*k+1] < node_cost[2*k]) begin
              tree_cost_reg[k] <= node_cost[2*k+1];
              tree_idx_reg[k]  <= node_idx[2*k+1];
            end else begin
              tree_cost_reg[k] <= node_cost[2*k];
              tree_idx_reg[k]  <= node_idx[2*k];
            end
          end
        end
      end
    end
  end

  assign bus.valid_out = valid_reg[LAT-1];
  assign bus.disp      = tree_idx_reg[1];
  assign bus.cost      = tree_cost_reg[1];
  assign bus.rowout    = row_reg[LAT-1];
  assign bus.colout    = col_reg[LAT-1];

endmodule

// File: tb/tb_census_match.sv
// Directed-vector bench for census_match (D = 16, latency 5).
module tb_census_match;
  import census_pkg::*;

  localparam int D   = 16;
  localparam int LAT = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  census_match_if bus();

  census_match #(.D(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [23:0] l;
    logic [23:0] r;
    logic [12:0] row;
    logic [12:0] col;
    logic [7:0]  disp;
    logic [4:0]  cost;
  } vec_t;

  typedef struct {
    int          due;
    logic [7:0]  disp;
    logic [4:0]  cost;
    logic [12:0] row;
    logic [12:0] col;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int checks   = 0;
  int errors   = 0;
  int edge_cnt = 0;

  logic [7:0]  last_disp = '0;
  logic [4:0]  last_cost = '0;
  logic [12:0] last_row  = '0;
  logic [12:0] last_col  = '0;

  // Expected results for the disparity-5 pattern at columns 0..4, worked out
  // by hand from 6 * popcount of the 4-bit code difference.
  logic [7:0] d5_disp [5] = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd3};
  logic [4:0] d5_cost [5] = '{5'd12, 5'd6, 5'd6, 5'd6, 5'd6};

  // Codes whose pairwise distance is 6 * (differing low nibble bits).
  function automatic logic [23:0] code(input int n);
    logic [23:0] c;
    logic [31:0] nn;
    nn = n;
    for (int b = 0; b < 4; b++) begin
      c[b*6 +: 6] = {6{nn[b]}};
    end
    return c;
  endfunction

  function automatic logic [23:0] rnd24();
    logic [31:0] u;
    u = $urandom;
    return u[23:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, got, exp, edge_cnt);
    end
  endtask

  function automatic void add(input logic vld, input logic [23:0] l, input logic [23:0] r,
                              input int row, input int col, input int disp, input int cost);
    vec_t v;
    v.vld  = vld;
    v.l    = l;
    v.r    = r;
    v.row  = 13'(row);
    v.col  = 13'(col);
    v.disp = 8'(disp);
    v.cost = 5'(cost);
    vecs.push_back(v);
  endfunction

  function automatic void add_d5(input int row, input int c);
    if (c < 5) add(1'b1, code(c), code(c + 5), row, c, int'(d5_disp[c]), int'(d5_cost[c]));
    else       add(1'b1, code(c), code(c + 5), row, c, 5, 0);
  endfunction

  task automatic drive(input vec_t v);
    exp_t e;
    @(negedge clk);
    bus.valid_in = v.vld;
    bus.censusL  = v.l;
    bus.censusR  = v.r;
    bus.row      = v.row;
    bus.col      = v.col;
    if (v.vld && !rst) begin
      e.due  = edge_cnt + LAT;
      e.disp = v.disp;
      e.cost = v.cost;
      e.row  = v.row;
      e.col  = v.col;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    vec_t v;
    v.vld = 1'b0; v.l = '0; v.r = '0; v.row = '0; v.col = '0; v.disp = '0; v.cost = '0;
    drive(v);
  endtask

  task automatic monitor_step();
    exp_t e;
    if (rst) begin
      chk("reset_outputs", {bus.valid_out, bus.disp, bus.cost, bus.rowout, bus.colout}, '0);
      sb.delete();
      last_disp = '0; last_cost = '0; last_row = '0; last_col = '0;
    end else begin
      while (sb.size() > 0 && sb[0].due < edge_cnt) begin
        chk("missed_output_edge", edge_cnt, sb[0].due);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == edge_cnt) begin
        e = sb.pop_front();
        chk("valid_out", bus.valid_out, 1);
        chk("result", {bus.disp, bus.cost, bus.rowout, bus.colout}, {e.disp, e.cost, e.row, e.col});
        $display("out edge=%0d row=%0d col=%0d disp=%0d cost=%0d", edge_cnt,
                 bus.rowout, bus.colout, bus.disp, bus.cost);
        last_disp = e.disp; last_cost = e.cost; last_row = e.row; last_col = e.col;
      end else begin
        chk("valid_out_idle", bus.valid_out, 0);
        chk("hold", {bus.disp, bus.cost, bus.rowout, bus.colout},
            {last_disp, last_cost, last_row, last_col});
      end
    end
  endtask

  initial begin
    logic [23:0] r;
    logic [23:0] x;
    vec_t v;

    bus.valid_in = 1'b0;
    bus.censusL  = '0;
    bus.censusR  = '0;
    bus.row      = '0;
    bus.col      = '0;

    fork
      forever begin
        @(posedge clk);
        edge_cnt++;
        #1;
        monitor_step();
      end
    join_none

    // Power-on reset, checked before the first clock edge.
    #1 rst = 1'b1;
    #1 chk("reset_async_initial", {bus.valid_out, bus.disp, bus.cost, bus.rowout, bus.colout}, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // A: L = R, random codes, a full 640-pixel row -> disp 0, cost 0.
    for (int c = 0; c < 640; c++) begin
      r = rnd24();
      add(1'b1, r, r, 0, c, 0, 0);
    end
    // B: every code identical -> ties everywhere, smallest d wins.
    for (int c = 0; c < 32; c++) add(1'b1, 24'hC3A55A, 24'hC3A55A, 1, c, 0, 0);
    // D: disparity-5 pattern with valid toggling; bubbles carry garbage.
    for (int c = 0; c <= 40; c++) begin
      add_d5(3, c);
      add(1'b0, rnd24(), rnd24(), $urandom_range(0, 8191), $urandom_range(0, 8191), 0, 0);
    end
    // E: row-edge masking. Prime the window with x, then ~x samples near col 0.
    x = 24'h3C965A;
    for (int c = 100; c < 116; c++) add(1'b1, x, x, 4, c, 0, 0);
    add(1'b1, x, ~x, 4, 0, 0, 24);   // matches at d>0 are off the row edge
    add(1'b1, x, ~x, 4, 1, 0, 24);
    add(1'b1, x, ~x, 4, 3, 3, 0);    // d == col is still a legal candidate
    add(1'b1, x, ~x, 4, 3, 0, 24);   // the match is now at d = col+1: excluded
    // C: continuous disparity-5 row, cols 0..300.
    for (int c = 0; c <= 300; c++) add_d5(5, c);

    for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);

    // Mid-row asynchronous reset right after col 300 was captured.
    @(posedge clk);
    #3;
    rst          = 1'b1;
    bus.valid_in = 1'b1;
    bus.censusL  = 24'h000000;
    bus.censusR  = 24'hFFFFFF;
    #1 chk("reset_async_midrow", {bus.valid_out, bus.disp, bus.cost, bus.rowout, bus.colout}, '0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // After reset the cleared window (zeros) matches L = 0; the k-th sample
    // sees k+1 copies of ~0 ahead of it, so the first zero sits at d = k+1.
    for (int k = 0; k < 16; k++) begin
      v.vld  = 1'b1;
      v.l    = 24'h000000;
      v.r    = 24'hFFFFFF;
      v.row  = 13'd5;
      v.col  = 13'(301 + k);
      v.disp = (k < 15) ? 8'(k + 1) : 8'd0;
      v.cost = (k < 15) ? 5'd0 : 5'd24;
      drive(v);
    end

    // Drain the pipeline with a bounded number of idle cycles.
    for (int i = 0; i < 20 && sb.size() > 0; i++) idle();
    chk("drain_pending", sb.size(), 0);
    repeat (3) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
